// File: rtl/sal_apb_pkg.sv
// Shared types and constants for the SAL APB initiator and its configuration-slave address map.
package sal_apb_pkg;

  localparam int SAL_ADDR_W = 12;
  localparam int SAL_DATA_W = 32;

  localparam logic [SAL_ADDR_W-1:0] SAL_HDR_ADDR       = 12'h001;
  localparam logic [SAL_ADDR_W-1:0] SAL_CH0_START_ADDR = 12'h10C;

  typedef enum logic [1:0] {
    APB_IDLE   = 2'd0,
    APB_SETUP  = 2'd1,
    APB_ACCESS = 2'd2,
    APB_RESP   = 2'd3
  } apb_state_e;

endpackage

// File: rtl/sal_apb_if.sv
// APB3 bus bundle between the SAL initiator and the configuration slave.
interface APB_IF
  import sal_apb_pkg::*;
#(
  parameter int ADDR_W = SAL_ADDR_W,
  parameter int DATA_W = SAL_DATA_W
);
  logic [ADDR_W-1:0] paddr;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport MST (output paddr, psel, penable, pwrite, pwdata,
               input  prdata, pready, pslverr);
  modport SLV (input  paddr, psel, penable, pwrite, pwdata,
               output prdata, pready, pslverr);
endinterface

// File: rtl/sal_apb_timer.sv
// Saturating ACCESS-phase wait counter; expired flags the last permitted wait cycle.
module sal_apb_timer #(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);
  localparam int unsigned CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != CNT_SAT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A zero timeout never expires, so the initiator waits indefinitely.
  assign expired = (TIMEOUT_CYC != 0) && (cnt_q == CNT_LAST);

endmodule

// File: rtl/sal_apb_master.sv
// Single-outstanding APB3 initiator: valid/ready request in, APB transfer, valid/ready response out.
module sal_apb_master
  import sal_apb_pkg::*;
#(
  parameter int unsigned ADDR_W      = SAL_ADDR_W,
  parameter int unsigned DATA_W      = SAL_DATA_W,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              rst,
  APB_IF.MST                apb_if,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout
);

  apb_state_e        state_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0] pwdata_q;
  logic              pwrite_q;
  logic              psel_q;
  logic              penable_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              rsp_err_q;
  logic              rsp_timeout_q;

  logic tmr_clr;
  logic tmr_inc;
  logic tmr_expired;

  assign tmr_clr = (state_q == APB_SETUP);
  assign tmr_inc = (state_q == APB_ACCESS) && !apb_if.pready;

  sal_apb_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmr_clr),
    .inc     (tmr_inc),
    .expired (tmr_expired)
  );

  assign req_ready = (state_q == APB_IDLE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= APB_IDLE;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pwrite_q      <= 1'b0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      case (state_q)
        APB_IDLE: begin
          if (req_valid) begin
            paddr_q   <= req_addr;
            pwdata_q  <= req_wdata;
            pwrite_q  <= req_write;
            psel_q    <= 1'b1;
            penable_q <= 1'b0;
            state_q   <= APB_SETUP;
          end
        end
        APB_SETUP: begin
          penable_q <= 1'b1;
          state_q   <= APB_ACCESS;
        end
        APB_ACCESS: begin
          // pready takes priority over a coincident timeout.
          if (apb_if.pready) begin
            rsp_rdata_q   <= pwrite_q ? '0 : apb_if.prdata;
            rsp_err_q     <= apb_if.pslverr;
            rsp_timeout_q <= 1'b0;
            rsp_valid_q   <= 1'b1;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            state_q       <= APB_RESP;
          end else if (tmr_expired) begin
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b1;
            rsp_timeout_q <= 1'b1;
            rsp_valid_q   <= 1'b1;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            state_q       <= APB_RESP;
          end
        end
        APB_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= APB_IDLE;
          end
        end
        default: state_q <= APB_IDLE;
      endcase
    end
  end

  assign apb_if.paddr   = paddr_q;
  assign apb_if.pwdata  = pwdata_q;
  assign apb_if.pwrite  = pwrite_q;
  assign apb_if.psel    = psel_q;
  assign apb_if.penable = penable_q;

  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule
